// File: rtl/tt_rr_arbiter.sv
// +--------------------------------------------------------------------------+
// | Module   : tt_rr_arbiter                                                  |
// | Brief    : 4-way round-robin arbiter, bounded tenure, lock, 1-cycle gap   |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tt_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);
  localparam logic [3:0] HOLD_SAT   = 4'd15;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       lock;
  logic       en;

  assign clk   = io_in[0];
  assign rst_n = io_in[1];
  assign req   = io_in[5:2];
  assign lock  = io_in[6];
  assign en    = io_in[7];

  logic [1:0] state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] gnt_id_q, gnt_id_d;
  logic [1:0] last_q, last_d;
  logic [3:0] hold_q, hold_d;
  logic       tout_q, tout_d;

  logic       arb_found;
  logic [1:0] arb_win;
  logic [3:0] owner_mask;
  logic       owner_req;
  logic       others_req;
  logic       revoke;

  // Rotating scan starts just after the previous owner, so it ends up last.
  always_comb begin
    logic [1:0] cand;
    arb_found = 1'b0;
    arb_win   = 2'd0;
    cand      = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!arb_found && req[cand]) begin
        arb_found = 1'b1;
        arb_win   = cand;
      end
    end
  end

  assign owner_mask = 4'b0001 << last_q;
  assign owner_req  = |(req & owner_mask);
  assign others_req = |(req & ~owner_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      gnt_q    <= 4'd0;
      gnt_id_q <= 2'd0;
      last_q   <= 2'd3;
      hold_q   <= 4'd0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      last_q   <= last_d;
      hold_q   <= hold_d;
      tout_q   <= tout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    revoke  = 1'b0;
    case (state_q)
      S_IDLE, S_GAP: begin
        if (en && arb_found) state_d = S_GRANT;
        else                 state_d = S_IDLE;
      end
      S_GRANT: begin
        if (!en || !owner_req) begin
          state_d = S_GAP;
        end else if ((hold_q >= HOLD_LIMIT) && !lock && others_req) begin
          state_d = S_GAP;
          revoke  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    last_d   = last_q;
    hold_d   = hold_q;
    tout_d   = 1'b0;
    if ((state_q != S_GRANT) && (state_d == S_GRANT)) begin
      gnt_d    = 4'b0001 << arb_win;
      gnt_id_d = arb_win;
      last_d   = arb_win;
      hold_d   = 4'd1;
    end else if (state_d == S_GRANT) begin
      if (hold_q != HOLD_SAT) hold_d = hold_q + 4'd1;
    end else begin
      gnt_d  = 4'd0;
      tout_d = revoke;
    end
  end

  always_comb begin
    io_out = {tout_q, (state_q == S_GRANT), gnt_id_q, gnt_q};
  end

endmodule

`default_nettype wire

// File: tb/tb_tt_rr_arbiter.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_tt_rr_arbiter                                               |
// | Brief    : Scoreboard bench for tt_rr_arbiter with directed vectors       |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_tt_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       lock;
  logic       en;
  logic [7:0] io_in;
  logic [7:0] io_out;

  assign io_in = {en, lock, req, rst_n, clk};

  tt_rr_arbiter #(.MAX_HOLD(8)) dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  typedef struct {
    logic [7:0] val;
    int         tid;
    int         idx;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   tid    = 0;
  int   sidx   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // io_out = {tout, busy, gnt_id[1:0], gnt[3:0]}
  function automatic logic [7:0] gv(input int k);
    return 8'h40 | 8'(k << 4) | 8'(1 << k);
  endfunction

  function automatic logic [7:0] gp(input int k, input logic t);
    return (t ? 8'h80 : 8'h00) | 8'(k << 4);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      if (io_out !== e.val) begin
        n_fail++;
        $display("FAIL t%0d step %0d: io_out=%h expected %h", e.tid, e.idx, io_out, e.val);
      end
    end
  end

  task automatic chk(input logic [7:0] exp, input int tag);
    n_vec++;
    if (io_out !== exp) begin
      n_fail++;
      $display("FAIL reset check %0d: io_out=%h expected %h", tag, io_out, exp);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic l, input logic e, input logic [7:0] x);
    exp_t ent;
    req  = r;
    lock = l;
    en   = e;
    ent.val = x;
    ent.tid = tid;
    ent.idx = sidx;
    sb.push_back(ent);
    sidx++;
    @(posedge clk);
    #1;
  endtask

  // Reset is asserted between clock edges so its effect is purely asynchronous.
  task automatic do_reset(input int tag);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    req   = 4'd0;
    lock  = 1'b0;
    en    = 1'b0;
    #1;
    chk(8'h00, tag);
    @(posedge clk);
    #1;
    chk(8'h00, tag + 100);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    sidx  = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, io_out=%h required finish", io_out);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'd0;
    lock  = 1'b0;
    en    = 1'b0;

    // Single requester grant, release, then en low blocks a new request.
    tid = 1;
    do_reset(1);
    step(4'b0001, 1'b0, 1'b1, gv(0));
    step(4'b0000, 1'b0, 1'b1, 8'h00);
    step(4'b0000, 1'b0, 1'b1, 8'h00);
    step(4'b0001, 1'b0, 1'b0, 8'h00);

    // Full contention: 8-cycle tenures, revoke gap with tout, rotation 0..3,0.
    tid = 2;
    do_reset(2);
    for (int k = 0; k < 4; k++) begin
      repeat (8) step(4'b1111, 1'b0, 1'b1, gv(k));
      step(4'b1111, 1'b0, 1'b1, gp(k, 1'b1));
    end
    step(4'b1111, 1'b0, 1'b1, gv(0));
    repeat (7) step(4'b1111, 1'b0, 1'b1, gv(0));
    // Release on the timeout edge counts as a release.
    step(4'b1110, 1'b0, 1'b1, gp(0, 1'b0));
    step(4'b1110, 1'b0, 1'b1, gv(1));

    // Lock holds requester 0 past the limit; dropping lock revokes.
    tid = 3;
    do_reset(3);
    repeat (20) step(4'b0011, 1'b1, 1'b1, gv(0));
    step(4'b0011, 1'b0, 1'b1, gp(0, 1'b1));
    step(4'b0011, 1'b0, 1'b1, gv(1));
    step(4'b0000, 1'b0, 1'b1, gp(1, 1'b0));
    step(4'b0000, 1'b0, 1'b1, gp(1, 1'b0));

    // Sole owner saturates its counter; a newcomer forces immediate revoke.
    tid = 4;
    do_reset(4);
    repeat (30) step(4'b0100, 1'b0, 1'b1, gv(2));
    step(4'b0101, 1'b0, 1'b1, gp(2, 1'b1));
    step(4'b0101, 1'b0, 1'b1, gv(0));

    // en low ends the tenure without tout, then re-grant and async reset.
    tid = 5;
    step(4'b0101, 1'b0, 1'b0, gp(0, 1'b0));
    step(4'b0101, 1'b0, 1'b0, gp(0, 1'b0));
    step(4'b0101, 1'b0, 1'b1, gv(2));
    step(4'b0101, 1'b0, 1'b1, gv(2));
    step(4'b0101, 1'b0, 1'b1, gv(2));
    do_reset(5);
    tid = 6;
    step(4'b1100, 1'b0, 1'b1, gv(2));
    step(4'b1100, 1'b0, 1'b1, gv(2));

    @(negedge clk);
    #2;
    n_vec++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
